slink_tx_pkt_arb: RTL and testbench
===================================

# slink_tx_pkt_arb

Two-source packet arbiter on the S-Link TX application interface, in the `link_clk` domain. It sits directly downstream of the APB bridge's TX packet port (`slink_apb_tgt` / `slink_apb_ini`) and upstream of the S-Link controller's TX app interface. It lets the APB bridge share one link with a second application packet source. Grant is round-robin, held for a whole packet, and released after the packet's last beat is advanced.

## Interface
Parameters:
- `APP_DATA_WIDTH`, 128: width of app data per beat; `BYTES = APP_DATA_WIDTH/8`.
- `LONG_PKT_DT_MIN`, 8'h20: a data_id at or above this value is a long packet; below it is a short packet.

Ports:
- `link_clk`  in  1  clock; single clock domain.
- `link_reset`  in  1  reset; asynchronous, active-high.
- `s0_tx_sop` / `s1_tx_sop`  in  1  source requests a packet; held until its first advance.
- `s0_tx_data_id` / `s1_tx_data_id`  in  8  packet data ID.
- `s0_tx_word_count` / `s1_tx_word_count`  in  16  byte count for a long packet, or payload for a short packet.
- `s0_tx_app_data` / `s1_tx_app_data`  in  APP_DATA_WIDTH  current beat data.
- `s0_tx_advance` / `s1_tx_advance`  out  1  beat consumed; only the granted source ever sees it.
- `tx_sop`, `tx_data_id`, `tx_word_count`, `tx_app_data`  out  1/8/16/APP_DATA_WIDTH  to the S-Link controller.
- `tx_advance`  in  1  controller consumed the current beat.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer `rr` = 0, meaning s0 is preferred.
- States and transitions:
  - IDLE: if any `sN_tx_sop` is high, register the grant and go to HDR.
    - Only one source requesting: that source is granted.
    - Both requesting: the source indicated by `rr` is granted.
  - HDR: drive the granted source's sop, data_id, word_count and app_data onto `tx_*`. Route `tx_advance` to that source's `sN_tx_advance`.
    - On the first advance, load `beats_left = nbeats - 1`.
    - If `nbeats == 1`, go to IDLE; otherwise go to DATA.
  - DATA: `tx_sop` = 0; data_id, word_count and app_data still pass through from the owner. Each advance decrements `beats_left`; the advance taken when `beats_left == 1` returns the block to IDLE.
- Beat count `nbeats`:
  - Short packet: 1.
  - Long packet: `max(1, ceil(word_count / BYTES))`, computed on the latched 16-bit word_count with no overflow. For `BYTES = 16`: `(wc + 15) >> 4`, using a 17-bit intermediate.
- `rr` update: on every return to IDLE after a completed packet, `rr` points to the other source.
- Outside HDR/DATA, all `tx_*` outputs are 0 and both `sN_tx_advance` are 0.
- Boundary rules:
  - Granted source drops `sop` in HDR before any advance: protocol abort. Return to IDLE, `rr` unchanged, no advance issued.
  - A request arriving during HDR/DATA from the non-owner waits; it is never dropped and never receives an advance.
  - `tx_advance` while IDLE is ignored.
  - `link_reset` mid-packet: everything returns immediately to its reset values; a partially sent packet is abandoned.

## Timing
- Request to `tx_sop` latency: 1 cycle. `sN_tx_sop` high in IDLE at edge N means `grant` and `tx_sop` are valid after edge N.
- `tx_*` muxing and `sN_tx_advance` routing are combinational from the registered grant and state; there is no added latency on advance.
- One mandatory IDLE cycle between consecutive packets.
- A 1-beat packet with `tx_advance` held high occupies 2 cycles (IDLE→HDR, HDR→IDLE). An n-beat packet with `tx_advance` held high occupies n+1 cycles.

## Structure
- Shared package `slink_pkg` holds:
  - `LONG_PKT_DT_MIN` default.
  - State enum `{IDLE, HDR, DATA}`.
  - Function `slink_nbeats(data_id, word_count, bytes)`, reused by the RX-side checkers.
- One natural sub-module: `slink_rr_arb2`, containing the two-request round-robin pointer and the registered one-hot grant.
- The mux, beat counter and FSM stay in the top module.

## Test plan
- s0 only, data_id 8'h32, wc 8, `tx_advance` tied high:
  - `tx_sop` and `grant` = 2'b01 one cycle after the request.
  - One `s0_tx_advance` pulse, then IDLE.
  - `s1_tx_advance` never pulses.
- Both sources request at the same edge out of reset:
  - s0 granted first, then s1 after one IDLE cycle.
  - Next simultaneous request grants s1 first, because `rr` = 1 after s0's packet.
- s1 long packet, data_id 8'h40, wc 40, `tx_advance` every other cycle:
  - Exactly 3 advances; `tx_sop` only during the first beat.
  - s0, requesting from beat 2 onward, is granted only after the 3rd advance plus one IDLE cycle.
- Short packet data_id 8'h02 wc 16'h1234, and long packet data_id 8'h20 wc 0: each completes after exactly 1 advance.
- s0 drops `sop` in HDR with `tx_advance` low: return to IDLE, `grant` = 0, `rr` unchanged, no advance on either source.
- Assert `link_reset` during DATA of a 3-beat packet: all outputs 0 in the same cycle; next simultaneous request grants s0.

Source files
------------

// File: rtl/slink_pkg.sv
// Shared S-Link definitions: FSM state encoding, default long-packet threshold
// and the beat-count helper used by the TX arbiter and the RX-side checkers.
package slink_pkg;

  // data_id values at or above this are long packets
  localparam logic [7:0] LONG_PKT_DT_MIN_DEFAULT = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } slink_state_e;

  // Beats in a packet: short packets are one beat; long packets carry
  // ceil(word_count / bytes) beats, never fewer than one. 17-bit sum avoids overflow.
  function automatic logic [15:0] slink_nbeats(
    input logic [7:0]  data_id,
    input logic [15:0] word_count,
    input int unsigned bytes,
    input logic [7:0]  dt_min = LONG_PKT_DT_MIN_DEFAULT
  );
    logic [16:0] sum;
    logic [16:0] quo;
    if (data_id < dt_min) return 16'd1;
    sum = 17'(word_count) + 17'(bytes - 1);
    quo = sum / 17'(bytes);
    return (quo == 17'd0) ? 16'd1 : 16'(quo);
  endfunction

endpackage

// File: rtl/slink_rr_arb2.sv
// Two-request round-robin arbiter with a registered one-hot grant.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : per-source requests
//   load      : capture a new grant from req (FSM idle with a request)
//   rel       : drop the current grant
//   done      : release follows a completed packet; move the pointer past the owner
//   grant[1:0]: one-hot owner, 2'b00 when nothing is granted
module slink_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       load,
  input  logic       rel,
  input  logic       done,
  output logic [1:0] grant
);

  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;

  // rr_q = 0 prefers s0, 1 prefers s1; it only moves on a completed packet
  always_comb begin
    grant_d = grant_q;
    rr_d    = rr_q;
    if (rel) begin
      grant_d = 2'b00;
      if (done) rr_d = grant_q[0];
    end else if (load) begin
      case (req)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = rr_q ? 2'b10 : 2'b01;
        default: grant_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
    end else begin
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/slink_tx_pkt_arb.sv
// Two-source packet arbiter in front of the S-Link controller TX app port.
// Grant is round-robin, held for a whole packet and released after its last beat.
// Ports:
//   link_clk, link_reset            : clock, asynchronous active-high reset
//   sN_tx_sop/data_id/word_count/app_data : source packet request and current beat
//   sN_tx_advance                   : beat consumed, only ever to the owner
//   tx_sop/data_id/word_count/app_data    : muxed owner packet to the controller
//   tx_advance                      : controller consumed the current beat
//   grant                           : one-hot owner, 2'b00 when idle
module slink_tx_pkt_arb
  import slink_pkg::*;
#(
  parameter int unsigned APP_DATA_WIDTH  = 128,
  parameter logic [7:0]  LONG_PKT_DT_MIN = LONG_PKT_DT_MIN_DEFAULT
) (
  input  logic                      link_clk,
  input  logic                      link_reset,
  input  logic                      s0_tx_sop,
  input  logic [7:0]                s0_tx_data_id,
  input  logic [15:0]               s0_tx_word_count,
  input  logic [APP_DATA_WIDTH-1:0] s0_tx_app_data,
  output logic                      s0_tx_advance,
  input  logic                      s1_tx_sop,
  input  logic [7:0]                s1_tx_data_id,
  input  logic [15:0]               s1_tx_word_count,
  input  logic [APP_DATA_WIDTH-1:0] s1_tx_app_data,
  output logic                      s1_tx_advance,
  output logic                      tx_sop,
  output logic [7:0]                tx_data_id,
  output logic [15:0]               tx_word_count,
  output logic [APP_DATA_WIDTH-1:0] tx_app_data,
  input  logic                      tx_advance,
  output logic [1:0]                grant
);

  localparam int unsigned BYTES = APP_DATA_WIDTH / 8;

  slink_state_e state_q, state_d;
  logic [15:0]  beats_left_q, beats_left_d;

  logic                      own_sop;
  logic [7:0]                own_id;
  logic [15:0]               own_wc;
  logic [APP_DATA_WIDTH-1:0] own_data;
  logic [15:0]               nbeats;
  logic                      adv;
  logic                      last_beat;
  logic                      abort;
  logic                      load;
  logic                      rel;

  // Owner select from the registered grant
  always_comb begin
    own_sop  = grant[1] ? s1_tx_sop        : s0_tx_sop;
    own_id   = grant[1] ? s1_tx_data_id    : s0_tx_data_id;
    own_wc   = grant[1] ? s1_tx_word_count : s0_tx_word_count;
    own_data = grant[1] ? s1_tx_app_data   : s0_tx_app_data;
  end

  // An advance counts in DATA, or in HDR only while the owner still holds sop
  assign nbeats    = slink_nbeats(own_id, own_wc, BYTES, LONG_PKT_DT_MIN);
  assign adv       = tx_advance && ((state_q == DATA) || ((state_q == HDR) && own_sop));
  assign last_beat = adv && (((state_q == HDR) && (nbeats == 16'd1)) ||
                             ((state_q == DATA) && (beats_left_q == 16'd1)));
  assign abort     = (state_q == HDR) && !own_sop;
  assign load      = (state_q == IDLE) && (s0_tx_sop || s1_tx_sop);
  assign rel       = last_beat || abort;

  slink_rr_arb2 u_arb (
    .clk   (link_clk),
    .rst   (link_reset),
    .req   ({s1_tx_sop, s0_tx_sop}),
    .load  (load),
    .rel   (rel),
    .done  (last_beat),
    .grant (grant)
  );

  // State and beat counter registers
  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      state_q      <= IDLE;
      beats_left_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Next state and remaining-beat count
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: if (load) state_d = HDR;
      HDR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (adv) begin
          beats_left_d = nbeats - 16'd1;
          state_d      = last_beat ? IDLE : DATA;
        end
      end
      DATA: begin
        if (adv) begin
          beats_left_d = beats_left_q - 16'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller-side mux and advance routing; all zero while idle
  always_comb begin
    tx_sop        = 1'b0;
    tx_data_id    = 8'd0;
    tx_word_count = 16'd0;
    tx_app_data   = '0;
    s0_tx_advance = 1'b0;
    s1_tx_advance = 1'b0;
    if (state_q != IDLE) begin
      tx_sop        = (state_q == HDR) && own_sop;
      tx_data_id    = own_id;
      tx_word_count = own_wc;
      tx_app_data   = own_data;
      s0_tx_advance = adv && grant[0];
      s1_tx_advance = adv && grant[1];
    end
  end

endmodule

// File: tb/tb_slink_tx_pkt_arb.sv
// Directed bench for slink_tx_pkt_arb with a packet scoreboard.
module tb_slink_tx_pkt_arb;

  localparam int unsigned W = 128;

  logic          link_clk = 1'b0;
  logic          link_reset;
  logic          s0_tx_sop, s1_tx_sop;
  logic [7:0]    s0_tx_data_id, s1_tx_data_id;
  logic [15:0]   s0_tx_word_count, s1_tx_word_count;
  logic [W-1:0]  s0_tx_app_data, s1_tx_app_data;
  logic          s0_tx_advance, s1_tx_advance;
  logic          tx_sop;
  logic [7:0]    tx_data_id;
  logic [15:0]   tx_word_count;
  logic [W-1:0]  tx_app_data;
  logic          tx_advance;
  logic [1:0]    grant;

  always #5 link_clk = ~link_clk;

  slink_tx_pkt_arb #(.APP_DATA_WIDTH(W)) dut (
    .link_clk         (link_clk),
    .link_reset       (link_reset),
    .s0_tx_sop        (s0_tx_sop),
    .s0_tx_data_id    (s0_tx_data_id),
    .s0_tx_word_count (s0_tx_word_count),
    .s0_tx_app_data   (s0_tx_app_data),
    .s0_tx_advance    (s0_tx_advance),
    .s1_tx_sop        (s1_tx_sop),
    .s1_tx_data_id    (s1_tx_data_id),
    .s1_tx_word_count (s1_tx_word_count),
    .s1_tx_app_data   (s1_tx_app_data),
    .s1_tx_advance    (s1_tx_advance),
    .tx_sop           (tx_sop),
    .tx_data_id       (tx_data_id),
    .tx_word_count    (tx_word_count),
    .tx_app_data      (tx_app_data),
    .tx_advance       (tx_advance),
    .grant            (grant)
  );

  typedef struct {
    logic [1:0]  g;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [7:0]  tag;
    int          nb;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  bit          in_pkt = 1'b0;
  bit          pend_idle = 1'b0;
  int          beat = 0;
  int          s0_adv_cnt = 0, s1_adv_cnt = 0;
  logic [15:0] s0_beat, s1_beat;
  logic [7:0]  s0_tag, s1_tag;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_data(input logic [7:0] tag, input logic [1:0] src,
                                           input logic [15:0] b);
    return {96'h0, tag, 6'h0, src, b};
  endfunction

  task automatic drive_data();
    s0_tx_app_data = mk_data(s0_tag, 2'b01, s0_beat);
    s1_tx_app_data = mk_data(s1_tag, 2'b10, s1_beat);
  endtask

  // Raise a request on a source; optionally queue the packet it must produce
  task automatic req(input int src, input logic [7:0] id, input logic [15:0] wc,
                     input logic [7:0] tag, input int nb, input bit expect_pkt);
    exp_t e;
    if (src == 0) begin
      s0_tx_sop = 1'b1; s0_tx_data_id = id; s0_tx_word_count = wc;
      s0_tag = tag; s0_beat = 16'd0;
    end else begin
      s1_tx_sop = 1'b1; s1_tx_data_id = id; s1_tx_word_count = wc;
      s1_tag = tag; s1_beat = 16'd0;
    end
    drive_data();
    if (expect_pkt) begin
      e.g = (src == 0) ? 2'b01 : 2'b10;
      e.id = id; e.wc = wc; e.tag = tag; e.nb = nb;
      sb.push_back(e);
    end
  endtask

  // Per-cycle observation of the controller side, sampled mid-cycle
  task automatic monitor();
    chk("adv_route", 128'({s1_tx_advance, s0_tx_advance}), 128'(tx_advance ? grant : 2'b00));
    if (grant == 2'b00) begin
      chk("idle_sop", 128'(tx_sop), 128'(0));
      chk("idle_hdr", 128'({tx_data_id, tx_word_count}), 128'(0));
      chk("idle_data", tx_app_data, 128'(0));
    end
    if (pend_idle) begin
      chk("gap_idle", 128'(grant), 128'(0));
      pend_idle = 1'b0;
    end
    if (in_pkt && !tx_advance) chk("owner_held", 128'(grant), 128'(cur.g));
    if (tx_advance && grant != 2'b00) begin
      if (!in_pkt) begin
        chk("sop_first", 128'(tx_sop), 128'(1));
        chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          in_pkt = 1'b1;
          beat = 0;
        end
      end else begin
        chk("sop_later", 128'(tx_sop), 128'(0));
      end
      if (in_pkt) begin
        chk("pkt_grant", 128'(grant), 128'(cur.g));
        chk("pkt_data_id", 128'(tx_data_id), 128'(cur.id));
        chk("pkt_wc", 128'(tx_word_count), 128'(cur.wc));
        chk("pkt_data", tx_app_data, mk_data(cur.tag, cur.g, 16'(beat)));
        beat++;
        if (beat == cur.nb) begin
          in_pkt = 1'b0;
          pend_idle = 1'b1;
        end
      end
    end
  endtask

  // One clock: observe at negedge, then let sources react to their advance
  task automatic step();
    logic a0, a1;
    @(negedge link_clk);
    monitor();
    a0 = s0_tx_advance;
    a1 = s1_tx_advance;
    @(posedge link_clk);
    #1;
    if (a0) begin s0_adv_cnt++; s0_tx_sop = 1'b0; s0_beat = s0_beat + 16'd1; end
    if (a1) begin s1_adv_cnt++; s1_tx_sop = 1'b0; s1_beat = s1_beat + 16'd1; end
    drive_data();
  endtask

  task automatic run_until_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0 && !in_pkt && !pend_idle && grant == 2'b00) break;
      step();
    end
    chk("done_in_time", 128'(sb.size() == 0 && !in_pkt), 128'(1));
  endtask

  initial begin
    int b0, b1, fin, g0;
    bit s0_raised;

    link_reset = 1'b1; tx_advance = 1'b0;
    s0_tx_sop = 1'b0; s0_tx_data_id = 8'd0; s0_tx_word_count = 16'd0;
    s1_tx_sop = 1'b0; s1_tx_data_id = 8'd0; s1_tx_word_count = 16'd0;
    s0_tag = 8'd0; s1_tag = 8'd0; s0_beat = 16'd0; s1_beat = 16'd0;
    drive_data();
    repeat (2) @(posedge link_clk);
    #1;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_sop", 128'(tx_sop), 128'(0));
    chk("rst_id", 128'(tx_data_id), 128'(0));
    chk("rst_wc", 128'(tx_word_count), 128'(0));
    chk("rst_data", tx_app_data, 128'(0));
    chk("rst_adv", 128'({s1_tx_advance, s0_tx_advance}), 128'(0));
    link_reset = 1'b0;

    // tx_advance while idle does nothing
    tx_advance = 1'b1;
    step(); step();
    chk("idle_adv_ignored", 128'(s0_adv_cnt + s1_adv_cnt), 128'(0));

    // Simultaneous requests out of reset, then s0 re-requests alongside waiting s1
    req(0, 8'h32, 16'd8, 8'h10, 1, 1'b1);
    req(1, 8'h05, 16'h00ab, 8'h11, 1, 1'b1);
    step(); chk("t2_first_s0", 128'(grant), 128'(2'b01));
    step(); chk("t2_gap1", 128'(grant), 128'(2'b00));
    req(0, 8'h07, 16'h0001, 8'h12, 1, 1'b1);
    step(); chk("t2_rr_s1", 128'(grant), 128'(2'b10));
    step(); chk("t2_gap2", 128'(grant), 128'(2'b00));
    step(); chk("t2_then_s0", 128'(grant), 128'(2'b01));
    run_until_done(10);

    // s0 alone, one-beat long packet, tx_advance held high
    b0 = s0_adv_cnt; b1 = s1_adv_cnt;
    req(0, 8'h32, 16'd8, 8'h20, 1, 1'b1);
    step();
    chk("t1_grant", 128'(grant), 128'(2'b01));
    chk("t1_sop", 128'(tx_sop), 128'(1));
    chk("t1_id", 128'(tx_data_id), 128'(8'h32));
    step();
    chk("t1_back_idle", 128'(grant), 128'(2'b00));
    chk("t1_s0_advs", 128'(s0_adv_cnt - b0), 128'(1));
    run_until_done(10);
    chk("t1_s1_no_adv", 128'(s1_adv_cnt - b1), 128'(0));

    // s1 3-beat packet, advance every other cycle; s0 waits from beat 2
    b1 = s1_adv_cnt;
    tx_advance = 1'b0;
    req(1, 8'h40, 16'd40, 8'h30, 3, 1'b1);
    step();
    chk("t4_grant", 128'(grant), 128'(2'b10));
    chk("t4_sop", 128'(tx_sop), 128'(1));
    s0_raised = 1'b0; fin = -1; g0 = -1;
    for (int i = 0; i < 40; i++) begin
      tx_advance = ~tx_advance;
      step();
      if (!s0_raised && (s1_adv_cnt - b1) >= 1) begin
        req(0, 8'h32, 16'd8, 8'h31, 1, 1'b1);
        s0_raised = 1'b1;
      end
      if (fin < 0 && (s1_adv_cnt - b1) == 3) fin = i;
      if (g0 < 0 && grant == 2'b01) g0 = i;
      if (s0_raised && sb.size() == 0 && !in_pkt && !pend_idle && grant == 2'b00) break;
    end
    chk("t4_s1_advs", 128'(s1_adv_cnt - b1), 128'(3));
    chk("t4_s0_wait", 128'(g0 - fin), 128'(1));
    run_until_done(10);

    // Short packet and zero-length long packet are single-beat
    tx_advance = 1'b1;
    b0 = s0_adv_cnt; b1 = s1_adv_cnt;
    req(0, 8'h02, 16'h1234, 8'h40, 1, 1'b1);
    run_until_done(10);
    chk("t5_short_advs", 128'(s0_adv_cnt - b0), 128'(1));
    req(1, 8'h20, 16'h0000, 8'h41, 1, 1'b1);
    run_until_done(10);
    chk("t5_wc0_advs", 128'(s1_adv_cnt - b1), 128'(1));

    // s0 drops sop in HDR: abort, pointer unchanged (still prefers s0)
    tx_advance = 1'b0;
    b0 = s0_adv_cnt; b1 = s1_adv_cnt;
    req(0, 8'h32, 16'd8, 8'h50, 1, 1'b0);
    step();
    chk("t6_grant", 128'(grant), 128'(2'b01));
    s0_tx_sop = 1'b0;
    step();
    chk("t6_abort_grant", 128'(grant), 128'(2'b00));
    chk("t6_abort_sop", 128'(tx_sop), 128'(0));
    chk("t6_no_adv", 128'((s0_adv_cnt - b0) + (s1_adv_cnt - b1)), 128'(0));
    tx_advance = 1'b1;
    req(0, 8'h03, 16'h0055, 8'h51, 1, 1'b1);
    req(1, 8'h04, 16'h0066, 8'h52, 1, 1'b1);
    step();
    chk("t6_rr_kept", 128'(grant), 128'(2'b01));
    run_until_done(10);

    // Reset in DATA of a 3-beat packet, with pointer at s1 beforehand
    req(0, 8'h32, 16'd8, 8'h60, 1, 1'b1);
    run_until_done(10);
    req(1, 8'h40, 16'd48, 8'h61, 3, 1'b1);
    step(); step();
    chk("t7_in_data_grant", 128'(grant), 128'(2'b10));
    chk("t7_in_data_sop", 128'(tx_sop), 128'(0));
    link_reset = 1'b1;
    #1;
    chk("t7_rst_grant", 128'(grant), 128'(0));
    chk("t7_rst_hdr", 128'({tx_sop, tx_data_id, tx_word_count}), 128'(0));
    chk("t7_rst_data", tx_app_data, 128'(0));
    chk("t7_rst_adv", 128'({s1_tx_advance, s0_tx_advance}), 128'(0));
    sb.delete();
    in_pkt = 1'b0;
    pend_idle = 1'b0;
    s1_tx_sop = 1'b0;
    step();
    link_reset = 1'b0;
    req(0, 8'h06, 16'h0007, 8'h62, 1, 1'b1);
    req(1, 8'h08, 16'h0009, 8'h63, 1, 1'b1);
    step();
    chk("t7_post_rst_s0", 128'(grant), 128'(2'b01));
    run_until_done(10);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
